// File: rtl/uart_cfg.sv
`timescale 1ns/1ps
// Configurable UART: a transmitter and an independent receiver on one clock.
// Data width, parity mode, stop-bit count and bit period are set by parameters.
//
// state    | meaning
// S_IDLE   | line idle; TX waits for start, RX waits for a low line
// S_START  | start bit (RX: half-bit wait, then false-start check)
// S_DATA   | payload bits, LSB first
// S_PARITY | parity bit (never entered when PARITY=0)
// S_STOP   | stop bit(s)
// S_BREAK  | RX only: framing error with the line still low; wait for high
module uart_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_fail,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = 1'(PARITY == 2);
  localparam bit            HAS_PAR   = (PARITY != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bits;
  logic                 tx_stop;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (start) begin
            tx_state <= S_START;
            tx_cnt   <= BIT_LAST;
            tx_shift <= send_data;
            tx_par   <= (^send_data) ^ ODD;
            tx_out   <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_START: begin
          if (tx_cnt == '0) begin
            tx_state <= S_DATA;
            tx_cnt   <= BIT_LAST;
            tx_bits  <= DATA_LAST;
            tx_out   <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bits == '0) begin
              if (HAS_PAR) begin
                tx_state <= S_PARITY;
                tx_out   <= tx_par;
              end else begin
                tx_state <= S_STOP;
                tx_stop  <= STOP_LAST;
                tx_out   <= 1'b1;
              end
            end else begin
              tx_bits  <= tx_bits - 1'b1;
              tx_shift <= tx_shift >> 1;
              tx_out   <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (tx_cnt == '0) begin
            tx_state <= S_STOP;
            tx_cnt   <= BIT_LAST;
            tx_stop  <= STOP_LAST;
            tx_out   <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == '0) begin
            if (tx_stop == 1'b0) begin
              tx_state <= S_IDLE;
              busy     <= 1'b0;
            end else begin
              tx_stop <= 1'b0;
              tx_cnt  <= BIT_LAST;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: begin
          tx_state <= S_IDLE;
          tx_out   <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Synchroniser resets to the idle level so leaving reset never looks like a start bit.
  logic rx_s1, rx_s2;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
    end
  end

  logic [2:0]           rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bits;
  logic                 rx_stop;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 perr_acc;
  logic                 ferr_acc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_bits       <= '0;
      rx_stop       <= 1'b0;
      rx_shift      <= '0;
      perr_acc      <= 1'b0;
      ferr_acc      <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_fail       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rx_s2) begin
            rx_state <= S_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        S_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
              rx_cnt   <= BIT_LAST;
              rx_bits  <= DATA_LAST;
              perr_acc <= 1'b0;
              ferr_acc <= 1'b0;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == '0) begin
            rx_cnt   <= BIT_LAST;
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_bits == '0) begin
              rx_state <= HAS_PAR ? S_PARITY : S_STOP;
              rx_stop  <= STOP_LAST;
            end else begin
              rx_bits <= rx_bits - 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (rx_cnt == '0) begin
            perr_acc <= rx_s2 ^ (^rx_shift) ^ ODD;
            rx_state <= S_STOP;
            rx_cnt   <= BIT_LAST;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == '0) begin
            if (rx_stop != 1'b0) begin
              rx_stop  <= 1'b0;
              rx_cnt   <= BIT_LAST;
              ferr_acc <= ferr_acc | ~rx_s2;
            end else begin
              rx_done       <= 1'b1;
              rx_data       <= rx_shift;
              rx_parity_err <= perr_acc;
              rx_frame_err  <= ferr_acc | ~rx_s2;
              rx_fail       <= perr_acc | ferr_acc | ~rx_s2;
              // A line still low here is a held break: report it once, then wait for idle.
              rx_state      <= rx_s2 ? S_IDLE : S_BREAK;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s2) rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
- Parametrised successor to the team's fixed-format UART: one transmitter and one receiver sharing a single clock.
- Generalised in data width, parity mode, stop-bit count and baud divisor.
- Adds a receive-line synchroniser, false-start rejection, and separate parity and framing error flags.
- Sits between the system bus logic and the serial pins; loopback use (tx_out wired to rx_in) is a supported configuration.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 4..65535.
- DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- send_data  input  DATA_BITS  transmit payload; sampled only on an accepted start.
- start  input  1  transmit request; accepted when start=1 and busy=0.
- busy  output  1  transmitter occupied.
- tx_out  output  1  serial transmit line; idle high.
- rx_in  input  1  serial receive line; asynchronous to clock.
- rx_data  output  DATA_BITS  last received payload; held until the next rx_done.
- rx_done  output  1  one-cycle pulse when a frame completes (good or bad).
- rx_fail  output  1  valid with rx_done: OR of the two error flags.
- rx_parity_err  output  1  valid with rx_done: parity mismatch (always 0 when PARITY=0).
- rx_frame_err  output  1  valid with rx_done: a stop bit sampled low.

Behaviour:
- Reset values (reset=0 at a clock edge): busy=0, tx_out=1, rx_data=0, rx_done=0, rx_fail=0, rx_parity_err=0, rx_frame_err=0. Both FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts the frame immediately. tx_out returns high on the reset edge and no rx_done is produced.
- TX FSM states: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- TX acceptance: in the cycle after an accepted start, busy=1 and tx_out=0. send_data is latched at acceptance, so later changes do not affect the frame.
- start while busy=1 is ignored, not queued.
- TX bit timing: each bit is driven for exactly CLKS_PER_BIT cycles. Data bits go LSB first.
- Parity bit = XOR of the data bits; inverted when PARITY=2.
- STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles. busy drops in the cycle after the last stop cycle.
- Back-to-back TX: start held high makes the next frame begin the cycle busy falls. Frame length is (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT+1 cycles including the acceptance cycle.
- RX synchroniser: rx_in passes through a 2-flop synchroniser, adding 2 cycles of latency. All RX decisions use the synchronised value.
- RX FSM states: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE, plus BREAK.
- IDLE: waits for the synchronised line = 0.
- START: counts CLKS_PER_BIT/2 (integer divide), then re-samples. If the line is 1 it is a false start: return to IDLE with no flags. If 0, continue.
- DATA, PARITY and STOP each sample once every CLKS_PER_BIT cycles at mid-bit. Data shifts in LSB first.
- rx_parity_err is set if the parity bit disagrees with the selected mode.
- rx_frame_err is set if any stop-bit sample is 0.
- rx_done pulses in the cycle after the mid-sample of the last stop bit. rx_data, rx_fail and both error flags update in that same cycle.
- rx_data is updated even on error. The flags hold until the next rx_done.
- BREAK: entered after a framing error while the line is still 0. The FSM waits for the line = 1 before returning to IDLE, so a held-low line yields exactly one errored frame.
- TX and RX are fully independent; simultaneous activity is legal.
- Counter widths are sized by $clog2 of the parameter values; counters do not wrap within a frame.

Test Plan:
- Defaults (CLKS_PER_BIT=16, 8N1) in loopback; send 8'hAA -> busy=1 for 160 cycles, then one rx_done with rx_data=8'hAA, rx_fail=0.
- PARITY=1, STOP_BITS=2 in loopback; send 8'h55 then 8'h07 back-to-back -> two rx_done pulses with rx_data 8'h55 then 8'h07, parity bits 0 then 1, no errors.
- PARITY=2; the bench drives rx_in with 8'h3C and a wrong parity bit -> rx_done with rx_data=8'h3C, rx_parity_err=1, rx_fail=1, rx_frame_err=0.
- Bench holds the stop bit low for a full bit and beyond -> exactly one rx_done with rx_frame_err=1. No further rx_done until the line has gone high and a new start bit arrives.
- A 3-cycle low glitch on rx_in while idle -> no rx_done, and the next valid frame 8'hC3 is received correctly.
- Pulse start during a frame -> ignored, busy timing unchanged. Assert reset=0 for one cycle mid-frame -> tx_out=1 and busy=0 on the next cycle, no rx_done, and the following frame 8'h81 round-trips correctly.
